ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single data port of the testbench RAM between two OBI-style requesters: m0 (core data interface) and m1 (testbench loader/debug master).
- Sits between the core/loader and the RAM inside the core wrapper.
- Arbitration is configurable:
  - round-robin; or
  - fixed priority to m0, with an aging counter that bounds m1's wait.
- Routes the 1-cycle-latency RAM response back to the master that owned the request.

Parameters:
- ADDR_WIDTH, 22, byte address width of the RAM port.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- ROUND_ROBIN, 1: 1 = round-robin; 0 = fixed priority m0 with aging for m1.
- MAX_WAIT, 8: in fixed-priority mode, the number of consecutive denied cycles after which m1 wins the next contention (range 1..255).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- m0_req_i / m1_req_i  input  1  request valid.
- m0_addr_i / m1_addr_i  input  ADDR_WIDTH  byte address.
- m0_we_i / m1_we_i  input  1  write enable.
- m0_be_i / m1_be_i  input  DATA_WIDTH/8  byte enables.
- m0_wdata_i / m1_wdata_i  input  DATA_WIDTH  write data.
- m0_gnt_o / m1_gnt_o  output  1  request accepted this cycle (combinational from req and state).
- m0_rvalid_o / m1_rvalid_o  output  1  response valid, exactly one cycle after gnt, for reads and writes.
- m0_rdata_o / m1_rdata_o  output  DATA_WIDTH  read data; valid only while the matching rvalid is 1.
- ram_req_o  output  1  RAM access this cycle.
- ram_addr_o  output  ADDR_WIDTH  RAM address.
- ram_we_o  output  1  RAM write enable.
- ram_be_o  output  DATA_WIDTH/8  RAM byte enables.
- ram_wdata_o  output  DATA_WIDTH  RAM write data.
- ram_rdata_i  input  DATA_WIDTH  RAM read data, one cycle after ram_req_o.
- conflict_cnt_o  output  32  count of cycles in which both reqs were high, saturating at 0xFFFFFFFF.

Behaviour:
- RAM has no stall: every granted request completes; ram_req_o = m0_gnt_o | m1_gnt_o.
- At most one gnt per cycle. The ram_* address/control/data mux follows the granted master. When neither is granted, ram_* outputs = 0.
- Single requester: granted the same cycle, in every mode.
- Round-robin mode:
  - last_q records the most recently granted master; reset value = m1, so m0 wins the first tie.
  - On contention the master not equal to last_q wins.
  - last_q updates on every grant.
- Fixed-priority mode:
  - m0 wins contention unless wait_q >= MAX_WAIT, in which case m1 wins.
  - wait_q (8-bit) increments, saturating, on each cycle where m1_req_i=1 and m1 is not granted; it clears to 0 when m1 is granted or m1_req_i=0.
- Response path:
  - owner_q (1 bit) and pend_q (1 bit) capture the granted master and ram_req_o each cycle.
  - mN_rvalid_o = pend_q & (owner_q==N).
  - mN_rdata_o = ram_rdata_i when that rvalid is 1, otherwise 0.
- Back-to-back: a master may be granted every cycle. Its rvalid for grant k coincides with gnt for grant k+1; no bubbles.
- conflict_cnt_o increments on each cycle with m0_req_i & m1_req_i; it holds at 0xFFFFFFFF.
- Reset (synchronous, rst_i=1 at a clock edge):
  - gnt outputs are forced 0 combinationally while rst_i=1.
  - Cleared: last_q=m1, wait_q=0, pend_q=0, owner_q=0, conflict_cnt_o=0.
  - A response pending when reset is applied is dropped (no rvalid after reset).
- All outputs are 0 during and immediately after reset until a request arrives.
- Requests are not required to hold stable without gnt; the arbiter is stateless with respect to request payloads.

Test Plan:
- Reset with both reqs high: rst_i=1 for 3 cycles → no gnt, no rvalid, conflict_cnt_o=0. On the first cycle after release, with ROUND_ROBIN=1, m0_gnt_o=1 and m1_gnt_o=0.
- m0 alone, write 0xDEADBEEF to 0x1000 with be=0xF, then read 0x1000 next cycle → gnt both cycles; rvalid cycles 2 and 3; m0_rdata_o=0xDEADBEEF in cycle 3; m1_rvalid_o stays 0.
- Round-robin, both request reads continuously for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; each rvalid follows its gnt by one cycle; conflict_cnt_o=6.
- ROUND_ROBIN=0, MAX_WAIT=3, both request continuously → m0 granted 3 cycles, m1 granted on the 4th, then the pattern repeats (m1 gets 1 in 4 cycles).
- Reset asserted the cycle after an m1 read grant → m1_rvalid_o stays 0; after release, last_q behaves as from power-up (m0 wins the tie).
- Force conflict_cnt to 0xFFFFFFFE, then 3 contention cycles → saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single data port of the testbench RAM between two OBI-style
// requesters: m0 (core data interface) and m1 (loader/debug master).
// Arbitration is round-robin, or fixed priority to m0 with an aging counter
// that bounds how long m1 can be starved. The RAM answers every access one
// cycle later, and the response is steered back to the master that owned it.
//
// Handshake: a master presents req with its payload; gnt in the same cycle
// means the access was issued to the RAM this cycle. There is no
// backpressure after gnt. Exactly one cycle after gnt, that master sees rvalid
// (reads and writes alike), with rdata meaningful only while rvalid is high.
// Requests need not be held without gnt; no payload is ever stored here.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_WAIT    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // master 0: core data interface
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  // master 1: loader / debug master
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  // RAM data port
  output logic                    ram_req_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  // statistics
  output logic [31:0]             conflict_cnt_o
);

  localparam int         BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  typedef enum logic {
    MASTER_M0 = 1'b0,
    MASTER_M1 = 1'b1
  } master_e;

  // Arbitration state
  master_e     last_q;      // most recently granted master (round-robin)
  logic [7:0]  wait_q;      // consecutive cycles m1 has been denied
  // Response tracking
  logic        pend_q;      // an access was issued last cycle
  master_e     owner_q;     // which master issued it
  // Statistics
  logic [31:0] conflict_cnt_q;

  logic contention;
  logic m0_pref;
  logic grant_m0;
  logic grant_m1;
  logic ram_req;

  // Decide the winner: m0_pref says who wins a tie; a lone requester always wins.
  always_comb begin
    contention = m0_req_i & m1_req_i;
    if (ROUND_ROBIN != 0) begin
      // m0 wins a tie unless it was the last one served
      m0_pref = (last_q == MASTER_M1);
    end else begin
      // m0 wins a tie until m1 has aged past its bound
      m0_pref = (wait_q < MAX_WAIT_L);
    end
    // Grants are forced low while reset is held so nothing reaches the RAM.
    grant_m1 = ~rst_i & m1_req_i & (~m0_req_i | ~m0_pref);
    grant_m0 = ~rst_i & m0_req_i & ~grant_m1;
    ram_req  = grant_m0 | grant_m1;
  end

  assign m0_gnt_o  = grant_m0;
  assign m1_gnt_o  = grant_m1;
  assign ram_req_o = ram_req;

  // Steer the granted master's command onto the RAM port; idle port drives zeros.
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (grant_m0) begin
      ram_addr_o  = m0_addr_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end else if (grant_m1) begin
      ram_addr_o  = m1_addr_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  // Track the last winner and how long m1 has been kept waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= MASTER_M1;
      wait_q <= '0;
    end else begin
      if (ram_req) begin
        last_q <= grant_m1 ? MASTER_M1 : MASTER_M0;
      end
      if (m1_req_i && !grant_m1) begin
        if (wait_q != 8'hFF) begin
          wait_q <= wait_q + 8'd1;
        end
      end else begin
        wait_q <= '0;
      end
    end
  end

  // Remember who issued this cycle's access so the response can be routed back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      owner_q <= MASTER_M0;
    end else begin
      pend_q  <= ram_req;
      owner_q <= grant_m1 ? MASTER_M1 : MASTER_M0;
    end
  end

  // Responses: rvalid is suppressed while reset is held so an in-flight
  // access caught by reset is dropped, never delivered.
  always_comb begin
    m0_rvalid_o = ~rst_i & pend_q & (owner_q == MASTER_M0);
    m1_rvalid_o = ~rst_i & pend_q & (owner_q == MASTER_M1);
    m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
  end

  // Count cycles where both masters wanted the port; sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else if (contention && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

  // The two grants are mutually exclusive by construction.
  one_grant_a: assert property (@(posedge clk_i) !(m0_gnt_o && m1_gnt_o));

  // Byte-enable width must cover the data bus exactly.
  if (BE_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Two instances share one stimulus:
// dut_rr (round-robin, backed by a small byte-enable RAM model) and
// dut_fp (fixed priority, MAX_WAIT=3, backed by an address-echo RAM).
module tb_ram_port_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset / shared stimulus ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [BW-1:0] m0_be, m1_be;
  logic [DW-1:0] m0_wdata, m1_wdata;

  always #5 clk = ~clk;

  // ---------------- round-robin instance ----------------
  logic          rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid;
  logic [DW-1:0] rr_m0_rdata, rr_m1_rdata;
  logic          rr_ram_req, rr_ram_we;
  logic [AW-1:0] rr_ram_addr;
  logic [BW-1:0] rr_ram_be;
  logic [DW-1:0] rr_ram_wdata;
  logic [DW-1:0] rr_ram_rdata = '0;
  logic [31:0]   rr_cnt;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .MAX_WAIT(8)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(rr_m0_gnt), .m0_rvalid_o(rr_m0_rvalid),
    .m0_rdata_o(rr_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(rr_m1_gnt), .m1_rvalid_o(rr_m1_rvalid),
    .m1_rdata_o(rr_m1_rdata),
    .ram_req_o(rr_ram_req), .ram_addr_o(rr_ram_addr), .ram_we_o(rr_ram_we),
    .ram_be_o(rr_ram_be), .ram_wdata_o(rr_ram_wdata), .ram_rdata_i(rr_ram_rdata),
    .conflict_cnt_o(rr_cnt)
  );

  // ---------------- fixed-priority instance ----------------
  logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic          fp_ram_req, fp_ram_we;
  logic [AW-1:0] fp_ram_addr;
  logic [BW-1:0] fp_ram_be;
  logic [DW-1:0] fp_ram_wdata;
  logic [DW-1:0] fp_ram_rdata = '0;
  logic [31:0]   fp_cnt;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .MAX_WAIT(3)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid),
    .m0_rdata_o(fp_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid),
    .m1_rdata_o(fp_m1_rdata),
    .ram_req_o(fp_ram_req), .ram_addr_o(fp_ram_addr), .ram_we_o(fp_ram_we),
    .ram_be_o(fp_ram_be), .ram_wdata_o(fp_ram_wdata), .ram_rdata_i(fp_ram_rdata),
    .conflict_cnt_o(fp_cnt)
  );

  // ---------------- RAM models ----------------
  // 256-word RAM, word index addr[9:2]; word i powers up as 0x1000_0000+i.
  // A write returns 0 on the data bus.
  logic [DW-1:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
  end

  always @(posedge clk) begin
    if (rr_ram_req) begin
      if (rr_ram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (rr_ram_be[b]) mem[rr_ram_addr[9:2]][8*b +: 8] <= rr_ram_wdata[8*b +: 8];
        end
        rr_ram_rdata <= '0;
      end else begin
        rr_ram_rdata <= mem[rr_ram_addr[9:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (fp_ram_req) fp_ram_rdata <= {10'h0, fp_ram_addr};
  end

  // ---------------- scoreboard counters / checker ----------------
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One call = one clock cycle: inputs change at negedge, outputs are
  // sampled 1 time unit later, well before the next posedge.
  task automatic apply(input logic rst_v, input logic r0, input logic r1, input logic we0,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] wd0);
    @(negedge clk);
    rst      = rst_v;
    m0_req   = r0;
    m1_req   = r1;
    m0_we    = we0;
    m1_we    = 1'b0;
    m0_addr  = a0;
    m1_addr  = a1;
    m0_wdata = wd0;
    m1_wdata = '0;
    m0_be    = 4'hF;
    m1_be    = 4'hF;
    #1;
  endtask

  // ---------------- vector table (round-robin instance) ----------------
  typedef struct {
    logic          rst, r0, r1, we0;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0;
    logic [1:0]    e_gnt;     // {m1_gnt, m0_gnt}
    logic [1:0]    e_rv;      // {m1_rvalid, m0_rvalid}
    logic [DW-1:0] e_rd0, e_rd1;
    logic [31:0]   e_cnt;
    logic [AW-1:0] e_raddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_v, input logic r0, input logic r1, input logic we0,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [DW-1:0] wd0,
                     input logic [1:0] e_gnt, input logic [1:0] e_rv,
                     input logic [DW-1:0] e_rd0, input logic [DW-1:0] e_rd1,
                     input logic [31:0] e_cnt, input logic [AW-1:0] e_raddr);
    vec_t v;
    v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.we0 = we0;
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    v.e_cnt = e_cnt; v.e_raddr = e_raddr;
    vecs.push_back(v);
  endtask

  // fixed-priority expected grant sequence
  logic [1:0] fp_exp_q[$];
  logic [1:0] fp_req_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [1:0] prev;
    logic [DW-1:0] e_wd;

    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_be = '0; m1_be = '0; m0_wdata = '0; m1_wdata = '0;

    //   rst r0 r1 we0 a0       a1       wd0           gnt    rv     rd0           rd1           cnt  raddr
    // reset held 3 cycles with both requesting
    add(1, 1, 1, 0, 'h10,   'h20,   0,            2'b00, 2'b00, 0,            0,            0, 0);
    add(1, 1, 1, 0, 'h10,   'h20,   0,            2'b00, 2'b00, 0,            0,            0, 0);
    add(1, 1, 1, 0, 'h10,   'h20,   0,            2'b00, 2'b00, 0,            0,            0, 0);
    // six contention cycles: m0 first, then alternating
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b01, 2'b00, 0,            0,            0, 'h10);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b10, 2'b01, 32'h10000004, 0,            1, 'h20);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b01, 2'b10, 0,            32'h10000008, 2, 'h10);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b10, 2'b01, 32'h10000004, 0,            3, 'h20);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b01, 2'b10, 0,            32'h10000008, 4, 'h10);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b10, 2'b01, 32'h10000004, 0,            5, 'h20);
    add(0, 0, 0, 0, 'h10,   'h20,   0,            2'b00, 2'b10, 0,            32'h10000008, 6, 0);
    // m0 alone: write DEADBEEF to 0x1000, read it back
    add(0, 1, 0, 1, 'h1000, 'h20,   32'hDEADBEEF, 2'b01, 2'b00, 0,            0,            6, 'h1000);
    add(0, 1, 0, 0, 'h1000, 'h20,   0,            2'b01, 2'b01, 0,            0,            6, 'h1000);
    add(0, 0, 0, 0, 'h1000, 'h20,   0,            2'b00, 2'b01, 32'hDEADBEEF, 0,            6, 0);
    // m1 alone back-to-back, then a tie goes to m0
    add(0, 0, 1, 0, 'h10,   'h1000, 0,            2'b10, 2'b00, 0,            0,            6, 'h1000);
    add(0, 0, 1, 0, 'h10,   'h20,   0,            2'b10, 2'b10, 0,            32'hDEADBEEF, 6, 'h20);
    add(0, 1, 1, 0, 'h10,   'h20,   0,            2'b01, 2'b10, 0,            32'h10000008, 6, 'h10);
    add(0, 0, 0, 0, 'h10,   'h20,   0,            2'b00, 2'b01, 32'h10000004, 0,            7, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      apply(v.rst, v.r0, v.r1, v.we0, v.a0, v.a1, v.wd0);
      e_wd = v.e_gnt[0] ? v.wd0 : '0;
      check($sformatf("row%0d gnt", i),    {30'h0, rr_m1_gnt, rr_m0_gnt}, {30'h0, v.e_gnt});
      check($sformatf("row%0d rvalid", i), {30'h0, rr_m1_rvalid, rr_m0_rvalid}, {30'h0, v.e_rv});
      check($sformatf("row%0d m0_rdata", i), rr_m0_rdata, v.e_rd0);
      check($sformatf("row%0d m1_rdata", i), rr_m1_rdata, v.e_rd1);
      check($sformatf("row%0d conflict_cnt", i), rr_cnt, v.e_cnt);
      check($sformatf("row%0d ram_req", i), {31'h0, rr_ram_req}, {31'h0, (v.e_gnt != 2'b00)});
      check($sformatf("row%0d ram_addr", i), {10'h0, rr_ram_addr}, {10'h0, v.e_raddr});
      check($sformatf("row%0d ram_we", i), {31'h0, rr_ram_we}, {31'h0, v.e_gnt[0] & v.we0});
      check($sformatf("row%0d ram_be", i), {28'h0, rr_ram_be}, (v.e_gnt != 2'b00) ? 32'hF : 32'h0);
      check($sformatf("row%0d ram_wdata", i), rr_ram_wdata, e_wd);
    end

    // ---- reset right after an m1 read grant drops its response ----
    apply(0, 0, 1, 0, 'h10, 'h20, 0);
    check("drop m1 gnt", {31'h0, rr_m1_gnt}, 32'h1);
    apply(1, 1, 1, 0, 'h10, 'h20, 0);
    check("drop m1 rvalid", {30'h0, rr_m1_rvalid, rr_m0_rvalid}, 32'h0);
    check("drop gnt in reset", {30'h0, rr_m1_gnt, rr_m0_gnt}, 32'h0);
    check("drop m1 rdata", rr_m1_rdata, 32'h0);
    // ---- m0 was last winner before reset; after reset m0 still wins a tie ----
    apply(0, 1, 0, 0, 'h10, 'h20, 0);
    check("pre-reset m0 gnt", {30'h0, rr_m1_gnt, rr_m0_gnt}, 32'h1);
    apply(1, 0, 0, 0, 'h10, 'h20, 0);
    check("drop m0 rvalid", {30'h0, rr_m1_rvalid, rr_m0_rvalid}, 32'h0);
    apply(0, 1, 1, 0, 'h10, 'h20, 0);
    check("post-reset tie", {30'h0, rr_m1_gnt, rr_m0_gnt}, 32'h1);
    check("post-reset cnt", rr_cnt, 32'h0);
    apply(0, 0, 0, 0, 'h10, 'h20, 0);
    check("post-reset m0 rvalid", {30'h0, rr_m1_rvalid, rr_m0_rvalid}, 32'h1);
    check("post-reset m0 rdata", rr_m0_rdata, 32'h10000004);
    check("post-reset cnt inc", rr_cnt, 32'h1);

    // ---- fixed priority, MAX_WAIT=3: aging and wait clear ----
    apply(1, 0, 0, 0, 'h10, 'h20, 0);
    // {m1_req, m0_req} and expected {m1_gnt, m0_gnt}
    fp_req_q = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    fp_exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    prev = 2'b00;
    foreach (fp_req_q[i]) begin
      apply(0, fp_req_q[i][0], fp_req_q[i][1], 0, 'h40, 'h80, 0);
      check($sformatf("fp cyc%0d gnt", i), {30'h0, fp_m1_gnt, fp_m0_gnt}, {30'h0, fp_exp_q[i]});
      check($sformatf("fp cyc%0d rvalid", i), {30'h0, fp_m1_rvalid, fp_m0_rvalid}, {30'h0, prev});
      prev = fp_exp_q[i];
    end
    apply(0, 0, 0, 0, 'h40, 'h80, 0);
    check("fp last rvalid", {30'h0, fp_m1_rvalid, fp_m0_rvalid}, {30'h0, prev});
    check("fp last m1 rdata", fp_m1_rdata, 32'h80);

    // ---- conflict counter saturation ----
    @(negedge clk);
    force dut_rr.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_rr.conflict_cnt_q;
    m0_req = 1'b1;
    m1_req = 1'b1;
    #1;
    check("sat preload", rr_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 1, 0, 'h10, 'h20, 0);
      check($sformatf("sat cyc%0d", k), rr_cnt, 32'hFFFF_FFFF);
    end
    apply(0, 0, 0, 0, 'h10, 'h20, 0);
    check("sat hold", rr_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
